// File: rtl/lcd_fb_arbiter.sv
// Frame buffer port arbiter: scanout reads take priority, pixel writes queue in a small FIFO.
// Optional LCD_FB_BLANK_EN: reads issued while the LCD is off return white instead of RAM data.
module lcd_fb_arbiter #(
    parameter int FB_PIXELS  = 23040,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_lcd_on,
    input  logic [1:0]  i_lcd_mode,
    input  logic        i_wr_valid,
    input  logic [14:0] i_wr_data,
    input  logic        i_vs_start,
    input  logic        i_pix_req,
    output logic        o_pix_valid,
    output logic [14:0] o_pix_data,
    output logic [14:0] o_ram_addr,
    output logic        o_ram_we,
    output logic [14:0] o_ram_wdata,
    input  logic [14:0] i_ram_rdata,
    output logic        o_wr_overflow,
    output logic        o_frame_done
);
    localparam int AW = 15;
    localparam int PW = 15;
    localparam int IW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] LAST_PIX = AW'(FB_PIXELS - 1);
    localparam logic [IW:0]   FULL_CNT = (IW+1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] WHITE    = 15'h7FFF;

    localparam logic [1:0] SLOT_IDLE  = 2'd0;
    localparam logic [1:0] SLOT_READ  = 2'd1;
    localparam logic [1:0] SLOT_WRITE = 2'd2;

    logic [AW-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [PW-1:0] r_fifo_data [FIFO_DEPTH];
    logic [IW-1:0] r_head;
    logic [IW-1:0] r_tail;
    logic [IW:0]   r_count;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [1:0]    r_rd_vld;
    logic [1:0]    r_rd_blank;

    logic          w_clear;
    logic          w_empty;
    logic          w_full;
    logic [1:0]    w_slot;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_wrap_w;
    logic [AW-1:0] w_wptr_next;
    logic [AW-1:0] w_rd_base;
    logic [AW-1:0] w_rptr_inc;
    logic          w_blank_req;

    assign w_clear     = !i_lcd_on || (i_lcd_mode == 2'd1);
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == FULL_CNT);
    assign w_slot      = i_pix_req ? SLOT_READ : (!w_empty ? SLOT_WRITE : SLOT_IDLE);
    assign w_pop       = (w_slot == SLOT_WRITE);
    // A pop in the same cycle frees the slot the incoming pixel needs.
    assign w_push      = !w_clear && i_wr_valid && (!w_full || w_pop);
    assign w_drop      = !w_clear && i_wr_valid && w_full && !w_pop;
    assign w_wrap_w    = (r_wptr == LAST_PIX);
    assign w_wptr_next = w_wrap_w ? '0 : r_wptr + 1'b1;
    assign w_rd_base   = i_vs_start ? '0 : r_rptr;
    assign w_rptr_inc  = (w_rd_base == LAST_PIX) ? '0 : w_rd_base + 1'b1;

`ifdef LCD_FB_BLANK_EN
    assign w_blank_req = !i_lcd_on;
`else
    assign w_blank_req = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_addr[r_tail] <= r_wptr;
            r_fifo_data[r_tail] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            o_wr_overflow <= 1'b0;
            o_frame_done  <= 1'b0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Dropped pixels still advance the pointer so later pixels keep their position.
            if (w_clear)         r_wptr <= '0;
            else if (i_wr_valid) r_wptr <= w_wptr_next;
            o_frame_done <= !w_clear && i_wr_valid && w_wrap_w;
            if (w_drop) o_wr_overflow <= 1'b1;
            if (i_pix_req)       r_rptr <= w_rptr_inc;
            else if (i_vs_start) r_rptr <= '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_ram_addr  <= '0;
            o_ram_we    <= 1'b0;
            o_ram_wdata <= '0;
        end else begin
            case (w_slot)
                SLOT_READ: begin
                    o_ram_addr <= w_rd_base;
                    o_ram_we   <= 1'b0;
                end
                SLOT_WRITE: begin
                    o_ram_addr  <= r_fifo_addr[r_head];
                    o_ram_wdata <= r_fifo_data[r_head];
                    o_ram_we    <= 1'b1;
                end
                default: o_ram_we <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_rd_vld    <= '0;
            r_rd_blank  <= '0;
            o_pix_valid <= 1'b0;
            o_pix_data  <= '0;
        end else begin
            r_rd_vld    <= {r_rd_vld[0], i_pix_req};
            r_rd_blank  <= {r_rd_blank[0], i_pix_req && w_blank_req};
            o_pix_valid <= r_rd_vld[1];
            if (r_rd_vld[1]) o_pix_data <= r_rd_blank[1] ? WHITE : i_ram_rdata;
        end
    end
endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// Randomised bench for lcd_fb_arbiter against a queue-based transaction model.
module tb_lcd_fb_arbiter;
    localparam int FB    = 23040;
    localparam int DEPTH = 4;
`ifdef LCD_FB_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        lcd_on = 1'b0;
    logic [1:0]  lcd_mode = 2'd0;
    logic        wr_valid = 1'b0;
    logic [14:0] wr_data = 15'h0;
    logic        vs_start = 1'b0;
    logic        pix_req = 1'b0;
    logic        pix_valid;
    logic [14:0] pix_data;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [14:0] ram_wdata;
    logic [14:0] ram_rdata;
    logic        wr_overflow;
    logic        frame_done;

    always #5 clk = ~clk;

    lcd_fb_arbiter #(.FB_PIXELS(FB), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_lcd_on(lcd_on), .i_lcd_mode(lcd_mode),
        .i_wr_valid(wr_valid), .i_wr_data(wr_data), .i_vs_start(vs_start), .i_pix_req(pix_req),
        .o_pix_valid(pix_valid), .o_pix_data(pix_data), .o_ram_addr(ram_addr), .o_ram_we(ram_we),
        .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata), .o_wr_overflow(wr_overflow),
        .o_frame_done(frame_done)
    );

    logic [14:0] ram [FB];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    typedef struct { int addr; logic [14:0] data; } wr_ent_t;
    typedef struct { int due;  logic [14:0] data; } rd_ent_t;

    logic [14:0] m_mem [FB];
    logic [14:0] exp_frame [FB];
    wr_ent_t     wq[$];
    rd_ent_t     rq[$];
    int          m_wptr, m_rptr;
    bit          m_ovf;
    bit          e_we, e_fd;
    logic [14:0] e_addr, e_wdata;
    bit          chk_en = 1'b0;
    int          cyc = 0;
    int          fd_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // One clock: check the state left by the previous edge, then drive and predict the next edge.
    task automatic step(input bit rst_n, input bit on, input logic [1:0] mode, input bit wv,
                        input logic [14:0] wd, input bit vs, input bit req);
        bit      exp_pv;
        int      base;
        wr_ent_t ent;
        rd_ent_t rd;
        @(negedge clk);
        cyc++;
        if (chk_en) begin
            chk("ram_we", ram_we, e_we);
            chk("ram_addr", ram_addr, e_addr);
            chk("ram_wdata", ram_wdata, e_wdata);
            chk("wr_overflow", wr_overflow, m_ovf);
            chk("frame_done", frame_done, e_fd);
            exp_pv = (rq.size() > 0) && (rq[0].due == cyc);
            chk("pix_valid", pix_valid, exp_pv);
            if (exp_pv) begin
                chk("pix_data", pix_data, rq[0].data);
                void'(rq.pop_front());
            end
            if (frame_done) fd_cnt++;
        end
        reset_n = rst_n; lcd_on = on; lcd_mode = mode; wr_valid = wv;
        wr_data = wd; vs_start = vs; pix_req = req;
        if (!rst_n) begin
            wq.delete(); rq.delete();
            m_wptr = 0; m_rptr = 0; m_ovf = 1'b0;
            e_we = 1'b0; e_fd = 1'b0; e_addr = 15'h0; e_wdata = 15'h0;
            chk_en = 1'b1;
        end else begin
            base = vs ? 0 : m_rptr;
            if (req) begin
                e_we = 1'b0;
                e_addr = 15'(base);
                rd.due = cyc + 3;
                rd.data = (BLANK_EN && !on) ? 15'h7FFF : m_mem[base];
                rq.push_back(rd);
                m_rptr = (base + 1) % FB;
            end else begin
                m_rptr = base;
                if (wq.size() > 0) begin
                    ent = wq.pop_front();
                    e_we = 1'b1; e_addr = 15'(ent.addr); e_wdata = ent.data;
                    m_mem[ent.addr] = ent.data;
                end else begin
                    e_we = 1'b0;
                end
            end
            e_fd = 1'b0;
            if (!on || mode == 2'd1) begin
                m_wptr = 0;
            end else if (wv) begin
                if (wq.size() < DEPTH) begin
                    ent.addr = m_wptr; ent.data = wd;
                    wq.push_back(ent);
                end else begin
                    m_ovf = 1'b1;
                end
                e_fd = (m_wptr == FB - 1);
                m_wptr = (m_wptr + 1) % FB;
            end
        end
    endtask

    task automatic idle(input bit on, input int n);
        for (int i = 0; i < n; i++) step(1'b1, on, 2'd0, 1'b0, 15'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [14:0] d;
        logic [14:0] dd [100];
        logic [14:0] y;
        bit          on;
        logic [1:0]  mode;
        for (int k = 0; k < FB; k++) begin
            ram[k] = 15'($urandom);
            m_mem[k] = ram[k];
        end

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'd0, 1'b0, 15'h0, 1'b0, 1'b0);
        idle(1'b1, 1);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_data", pix_data, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_overflow", wr_overflow, 0);

        // Full frame at one pixel per two cycles, with scanout reads in the gaps.
        fd_cnt = 0;
        for (int i = 0; i < 2 * FB; i++) begin
            if (i % 2 == 0) begin
                d = 15'($urandom);
                exp_frame[i / 2] = d;
                step(1'b1, 1'b1, 2'd0, 1'b1, d, 1'b0, 1'b0);
            end else begin
                step(1'b1, 1'b1, 2'd0, 1'b0, 15'h0, 1'b0, i < 2 * FB - 1);
            end
        end
        idle(1'b1, 6);
        chk("frame_done_count", fd_cnt, 1);
        chk("frame_no_overflow", wr_overflow, 0);

        // Read pointer sits at FB-1; a frame start with a request must read address 0.
        step(1'b1, 1'b1, 2'd0, 1'b0, 15'h0, 1'b1, 1'b1);
        idle(1'b1, 1);
        chk("wrap_addr0", ram_addr, 0);
        chk("wrap_read_we", ram_we, 0);
        step(1'b1, 1'b1, 2'd0, 1'b0, 15'h0, 1'b0, 1'b1);
        idle(1'b1, 1);
        chk("wrap_addr1", ram_addr, 1);
        idle(1'b1, 4);

        for (int k = 0; k < FB; k++) chk("frame_mem", ram[k], exp_frame[k]);

        step(1'b1, 1'b1, 2'd0, 1'b0, 15'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 2'd0, 1'b0, 15'h0, 1'b0, 1'b1);
            idle(1'b1, 1);
        end
        step(1'b1, 1'b1, 2'd0, 1'b0, 15'h0, 1'b0, 1'b1);
        idle(1'b1, 1);
        chk("lat_addr", ram_addr, 5);
        idle(1'b1, 2);
        chk("lat_valid", pix_valid, 1);
        chk("lat_data", pix_data, exp_frame[5]);
        idle(1'b1, 2);

        // Writes every cycle against reads every other cycle overrun the FIFO.
        for (int i = 0; i < 40; i++)
            step(1'b1, 1'b1, 2'd0, 1'b1, 15'($urandom), 1'b0, i % 2 == 0);
        idle(1'b1, 12);
        chk("ovf_set", wr_overflow, 1);

        // VBlank arriving with a pixel: that pixel is dropped, queued ones still commit.
        step(1'b1, 1'b1, 2'd1, 1'b0, 15'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2'd1, 1'b0, 15'h0, 1'b0, 1'b0);
        for (int j = 0; j < 100; j++) begin
            dd[j] = 15'($urandom);
            step(1'b1, 1'b1, 2'd0, 1'b1, dd[j], 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 2'd1, 1'b1, 15'($urandom), 1'b0, 1'b0);
        y = 15'($urandom);
        step(1'b1, 1'b1, 2'd0, 1'b1, y, 1'b0, 1'b0);
        idle(1'b1, 6);
        chk("vbl_addr0", ram[0], y);
        chk("vbl_addr1", ram[1], dd[1]);
        chk("vbl_addr98", ram[98], dd[98]);
        chk("vbl_addr99", ram[99], dd[99]);

        step(1'b1, 1'b0, 2'd0, 1'b0, 15'h0, 1'b1, 1'b1);
        idle(1'b0, 3);
        chk("lcd_off_valid", pix_valid, 1);
        chk("lcd_off_data", pix_data, BLANK_EN ? 15'h7FFF : y);
        idle(1'b1, 2);

        on = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) on = !on;
            mode = 2'($urandom_range(0, 3));
            if (mode == 2'd1 && $urandom_range(0, 3) != 0) mode = 2'd0;
            step(!(i >= 1500 && i < 1502), on, mode, $urandom_range(0, 3) != 0,
                 15'($urandom), $urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0);
        end
        idle(1'b1, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
